maq_bcd_mod: RTL and testbench



---
 rtl/maq_bcd_pkg.sv | 15 +
 rtl/maq_bcd_digit.sv | 38 +++
 rtl/maq_bcd_mod.sv | 138 +++++++++++++
 tb/tb_maq_bcd_mod.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/maq_bcd_pkg.sv
// Shared BCD types, digit limits and the binary-to-BCD helper used by the
// modulo counter and its digit cells.
package maq_bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    // Convert a binary value 0..99 to packed {msd, lsd} BCD.
    function automatic logic [7:0] to_bcd(input int value);
        return {4'(value / 10), 4'(value % 10)};
    endfunction

endpackage

// File: rtl/maq_bcd_digit.sv
// Single BCD digit up/down counter. Counts 0..TERMINAL, wraps at either end
// and exposes its terminal-count flags so the parent can chain digits.
module maq_bcd_digit
    import maq_bcd_pkg::*;
#(
    parameter bcd_digit_t TERMINAL    = BCD_MAX,
    parameter bcd_digit_t RESET_DIGIT = BCD_MIN
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  bcd_digit_t load_value,
    input  logic       step,
    input  logic       up,
    output bcd_digit_t value,
    output logic       at_max,
    output logic       at_min
);

    assign at_max = (value == TERMINAL);
    assign at_min = (value == BCD_MIN);

    // Digit register: reset, then preset, then a single up or down step.
    always_ff @(posedge clock) begin
        if (reset) begin
            value <= RESET_DIGIT;
        end else if (load) begin
            value <= load_value;
        end else if (step) begin
            if (up) begin
                value <= at_max ? BCD_MIN : value + 4'd1;
            end else begin
                value <= at_min ? TERMINAL : value - 4'd1;
            end
        end
    end

endmodule

// File: rtl/maq_bcd_mod.sv
// Two-digit BCD modulo counter (modulus 2..99) with validated preset load
// and single-cycle carry, borrow and load-error pulses. Stages cascade by
// feeding one stage's carry into the next stage's enable.
module maq_bcd_mod
    import maq_bcd_pkg::*;
#(
    parameter int MODULO      = 60,
    parameter int RESET_VALUE = 0
) (
    input  logic       maq_bcd_mod_clock,
    input  logic       maq_bcd_mod_reset,
    input  logic       maq_bcd_mod_enable,
    input  logic       maq_bcd_mod_up,
    input  logic       maq_bcd_mod_load,
    input  logic [3:0] maq_bcd_mod_load_lsd,
    input  logic [3:0] maq_bcd_mod_load_msd,
    output logic [3:0] maq_bcd_mod_lsd,
    output logic [3:0] maq_bcd_mod_msd,
    output logic       maq_bcd_mod_carry,
    output logic       maq_bcd_mod_borrow,
    output logic       maq_bcd_mod_load_err
);

    generate
        if (MODULO < 2 || MODULO > 99) begin : g_bad_modulo
            $error("maq_bcd_mod: MODULO must be within 2..99");
        end
        if (RESET_VALUE < 0 || RESET_VALUE >= MODULO) begin : g_bad_reset
            $error("maq_bcd_mod: RESET_VALUE must be within 0..MODULO-1");
        end
    endgenerate

    localparam logic [7:0] TOP_BCD   = to_bcd(MODULO - 1);
    localparam logic [7:0] RESET_BCD = to_bcd(RESET_VALUE);
    localparam bcd_digit_t TOP_MSD   = TOP_BCD[7:4];
    localparam bcd_digit_t TOP_LSD   = TOP_BCD[3:0];
    localparam logic [7:0] MODULO_B  = 8'(MODULO);

    bcd_digit_t lsd_q;
    bcd_digit_t msd_q;
    logic       lsd_max;
    logic       lsd_min;
    logic       msd_max;
    logic       msd_min;

    logic [7:0] load_bin;
    logic       load_ok;
    logic       load_bad;
    logic       at_top;
    logic       at_zero;
    logic       wrap_up;
    logic       wrap_down;
    logic       preset;
    logic       step_lsd;
    logic       step_msd;
    bcd_digit_t preset_lsd;
    bcd_digit_t preset_msd;

    // A preset is legal only with two valid BCD digits inside the modulus.
    assign load_bin = ({4'd0, maq_bcd_mod_load_msd} * 8'd10) + {4'd0, maq_bcd_mod_load_lsd};
    assign load_ok  = maq_bcd_mod_load
                    && (maq_bcd_mod_load_lsd <= BCD_MAX)
                    && (maq_bcd_mod_load_msd <= BCD_MAX)
                    && (load_bin < MODULO_B);
    assign load_bad = maq_bcd_mod_load && !load_ok;

    // The full-count wrap is handled here rather than in the digits, since
    // the units digit wraps at TOP_LSD instead of 9 on the top tens value.
    assign at_top    = msd_max && (lsd_q == TOP_LSD);
    assign at_zero   = msd_min && lsd_min;
    assign wrap_up   = maq_bcd_mod_enable && !maq_bcd_mod_load &&  maq_bcd_mod_up && at_top;
    assign wrap_down = maq_bcd_mod_enable && !maq_bcd_mod_load && !maq_bcd_mod_up && at_zero;

    // Any load request (even a rejected one) swallows the enable.
    assign preset   = load_ok || wrap_up || wrap_down;
    assign step_lsd = maq_bcd_mod_enable && !maq_bcd_mod_load && !wrap_up && !wrap_down;
    assign step_msd = step_lsd && (maq_bcd_mod_up ? lsd_max : lsd_min);

    // Select what the digits are forced to: a user preset or a wrap target.
    always_comb begin
        preset_lsd = TOP_LSD;
        preset_msd = TOP_MSD;
        if (load_ok) begin
            preset_lsd = maq_bcd_mod_load_lsd;
            preset_msd = maq_bcd_mod_load_msd;
        end else if (wrap_up) begin
            preset_lsd = BCD_MIN;
            preset_msd = BCD_MIN;
        end
    end

    maq_bcd_digit #(
        .TERMINAL    (BCD_MAX),
        .RESET_DIGIT (RESET_BCD[3:0])
    ) u_units (
        .clock      (maq_bcd_mod_clock),
        .reset      (maq_bcd_mod_reset),
        .load       (preset),
        .load_value (preset_lsd),
        .step       (step_lsd),
        .up         (maq_bcd_mod_up),
        .value      (lsd_q),
        .at_max     (lsd_max),
        .at_min     (lsd_min)
    );

    maq_bcd_digit #(
        .TERMINAL    (TOP_MSD),
        .RESET_DIGIT (RESET_BCD[7:4])
    ) u_tens (
        .clock      (maq_bcd_mod_clock),
        .reset      (maq_bcd_mod_reset),
        .load       (preset),
        .load_value (preset_msd),
        .step       (step_msd),
        .up         (maq_bcd_mod_up),
        .value      (msd_q),
        .at_max     (msd_max),
        .at_min     (msd_min)
    );

    assign maq_bcd_mod_lsd = lsd_q;
    assign maq_bcd_mod_msd = msd_q;

    // Event pulses: registered every clock so each lasts exactly one cycle.
    always_ff @(posedge maq_bcd_mod_clock) begin
        if (maq_bcd_mod_reset) begin
            maq_bcd_mod_carry    <= 1'b0;
            maq_bcd_mod_borrow   <= 1'b0;
            maq_bcd_mod_load_err <= 1'b0;
        end else begin
            maq_bcd_mod_carry    <= wrap_up;
            maq_bcd_mod_borrow   <= wrap_down;
            maq_bcd_mod_load_err <= load_bad;
        end
    end

endmodule

// File: tb/tb_maq_bcd_mod.sv
// Directed bench for maq_bcd_mod: four instances (mod 60, mod 24,
// mod 60 with reset value 12, mod 2) driven from a vector table plus
// hand-written multi-cycle sequences.
module tb_maq_bcd_mod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rst;
    logic [3:0] en;
    logic [3:0] up;
    logic [3:0] ld;
    logic [3:0] carry;
    logic [3:0] borrow;
    logic [3:0] lerr;
    logic [3:0] lmsd [4];
    logic [3:0] llsd [4];
    logic [3:0] msd  [4];
    logic [3:0] lsd  [4];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        maq_bcd_mod #(
            .MODULO      (g == 1 ? 24 : (g == 3 ? 2 : 60)),
            .RESET_VALUE (g == 2 ? 12 : 0)
        ) u_dut (
            .maq_bcd_mod_clock    (clk),
            .maq_bcd_mod_reset    (rst[g]),
            .maq_bcd_mod_enable   (en[g]),
            .maq_bcd_mod_up       (up[g]),
            .maq_bcd_mod_load     (ld[g]),
            .maq_bcd_mod_load_lsd (llsd[g]),
            .maq_bcd_mod_load_msd (lmsd[g]),
            .maq_bcd_mod_lsd      (lsd[g]),
            .maq_bcd_mod_msd      (msd[g]),
            .maq_bcd_mod_carry    (carry[g]),
            .maq_bcd_mod_borrow   (borrow[g]),
            .maq_bcd_mod_load_err (lerr[g])
        );
    end

    typedef struct {
        int         d;
        bit         r;
        bit         e;
        bit         u;
        bit         l;
        logic [3:0] lm;
        logic [3:0] ll;
        int         em;
        int         el;
        bit         ec;
        bit         eb;
        bit         ee;
    } vec_t;

    vec_t tbl[$];

    task automatic idle_all();
        rst = '0;
        en  = '0;
        up  = '0;
        ld  = '0;
        for (int i = 0; i < 4; i++) begin
            lmsd[i] = 4'd0;
            llsd[i] = 4'd0;
        end
    endtask

    task automatic drive(input int d, input bit r, input bit e, input bit u,
                         input bit l, input logic [3:0] m, input logic [3:0] l4);
        idle_all();
        rst[d]  = r;
        en[d]   = e;
        up[d]   = u;
        ld[d]   = l;
        lmsd[d] = m;
        llsd[d] = l4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_dut(input int d, input string tag, input int em, input int el,
                           input bit ec, input bit eb, input bit ee);
        chk($sformatf("%s d%0d msd", tag, d),    {4'd0, msd[d]}, 8'(em));
        chk($sformatf("%s d%0d lsd", tag, d),    {4'd0, lsd[d]}, 8'(el));
        chk($sformatf("%s d%0d carry", tag, d),  {7'd0, carry[d]}, {7'd0, ec});
        chk($sformatf("%s d%0d borrow", tag, d), {7'd0, borrow[d]}, {7'd0, eb});
        chk($sformatf("%s d%0d lerr", tag, d),   {7'd0, lerr[d]}, {7'd0, ee});
    endtask

    initial begin
        int v;

        //                 d  r  e  u  l  lm     ll     em el ec eb ee
        tbl.push_back('{0, 0, 0, 0, 1, 4'd4, 4'd5, 4, 5, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 4'd6, 4'd0, 4, 5, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 4'd0, 4'd0, 4, 5, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 4'd1, 4'hA, 4, 5, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 1, 4'hA, 4'd0, 4, 5, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 1, 4'd5, 4'd9, 5, 9, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 0, 4'd0, 4'd0, 0, 0, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 4'd0, 4'd0, 5, 9, 0, 1, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 4'd0, 4'd0, 5, 8, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 0, 4'd0, 4'd0, 5, 9, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 1, 4'd1, 4'd2, 1, 2, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 0, 4'd0, 4'd0, 1, 3, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 4'd0, 4'd0, 1, 2, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 4'd1, 4'd0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 9, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 0, 4'd0, 4'd0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 1, 4'd0, 4'd0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 4'd0, 4'd0, 5, 9, 0, 1, 0});
        tbl.push_back('{0, 1, 1, 1, 1, 4'd4, 4'd5, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 1, 4'd7, 4'd0, 0, 0, 0, 0, 1});
        tbl.push_back('{1, 0, 1, 0, 0, 4'd0, 4'd0, 2, 3, 0, 1, 0});
        tbl.push_back('{1, 0, 1, 0, 0, 4'd0, 4'd0, 2, 2, 0, 0, 0});
        tbl.push_back('{1, 0, 1, 1, 0, 4'd0, 4'd0, 2, 3, 0, 0, 0});
        tbl.push_back('{1, 0, 1, 1, 0, 4'd0, 4'd0, 0, 0, 1, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 1, 4'd2, 4'd4, 0, 0, 0, 0, 1});
        tbl.push_back('{1, 0, 0, 0, 1, 4'd2, 4'd3, 2, 3, 0, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 0, 4'd0, 4'd0, 2, 2, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 1, 4'd1, 4'd9, 1, 9, 0, 0, 0});
        tbl.push_back('{1, 0, 1, 1, 0, 4'd0, 4'd0, 2, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 1, 4'd0, 4'd9, 0, 9, 0, 0, 0});

        // Reset held three clocks with enable high on every instance.
        idle_all();
        rst = 4'b1111;
        en  = 4'b1111;
        up  = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_dut(0, "reset", 0, 0, 0, 0, 0);
            chk_dut(1, "reset", 0, 0, 0, 0, 0);
            chk_dut(2, "reset", 1, 2, 0, 0, 0);
            chk_dut(3, "reset", 0, 0, 0, 0, 0);
        end

        // Vector table, one clock per entry.
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].d, tbl[i].r, tbl[i].e, tbl[i].u, tbl[i].l, tbl[i].lm, tbl[i].ll);
            tick();
            chk_dut(tbl[i].d, $sformatf("vec%0d", i), tbl[i].em, tbl[i].el,
                    tbl[i].ec, tbl[i].eb, tbl[i].ee);
        end

        // Full up sweep on mod 60, then carry must drop with enable low.
        drive(0, 1, 0, 0, 0, 4'd0, 4'd0);
        tick();
        chk_dut(0, "upwrap_rst", 0, 0, 0, 0, 0);
        for (int k = 1; k <= 60; k++) begin
            drive(0, 0, 1, 1, 0, 4'd0, 4'd0);
            tick();
            v = k % 60;
            chk_dut(0, $sformatf("upwrap%0d", k), v / 10, v % 10, k == 60, 0, 0);
        end
        drive(0, 0, 0, 1, 0, 4'd0, 4'd0);
        tick();
        chk_dut(0, "upwrap_idle", 0, 0, 0, 0, 0);

        // Full down sweep on mod 24.
        drive(1, 1, 0, 0, 0, 4'd0, 4'd0);
        tick();
        chk_dut(1, "dnwrap_rst", 0, 0, 0, 0, 0);
        for (int k = 1; k <= 24; k++) begin
            drive(1, 0, 1, 0, 0, 4'd0, 4'd0);
            tick();
            v = (24 - k) % 24;
            chk_dut(1, $sformatf("dnwrap%0d", k), v / 10, v % 10, 0, k == 1, 0);
        end

        // Reset mid-count with enable held high, RESET_VALUE = 12.
        drive(2, 0, 0, 0, 1, 4'd3, 4'd6);
        tick();
        chk_dut(2, "midrst_load", 3, 6, 0, 0, 0);
        drive(2, 0, 1, 1, 0, 4'd0, 4'd0);
        tick();
        chk_dut(2, "midrst_step", 3, 7, 0, 0, 0);
        drive(2, 1, 1, 1, 0, 4'd0, 4'd0);
        tick();
        chk_dut(2, "midrst_rst", 1, 2, 0, 0, 0);
        drive(2, 0, 1, 1, 0, 4'd0, 4'd0);
        tick();
        chk_dut(2, "midrst_resume", 1, 3, 0, 0, 0);

        // Mod 2 with enable held: carry on every up wrap, borrow on every down wrap.
        drive(3, 1, 0, 0, 0, 4'd0, 4'd0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            drive(3, 0, 1, 1, 0, 4'd0, 4'd0);
            tick();
            chk_dut(3, $sformatf("mod2up%0d", k), 0, k % 2, (k % 2) == 0, 0, 0);
        end
        for (int k = 1; k <= 3; k++) begin
            drive(3, 0, 1, 0, 0, 4'd0, 4'd0);
            tick();
            chk_dut(3, $sformatf("mod2dn%0d", k), 0, k % 2, 0, (k % 2) == 1, 0);
        end

        idle_all();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
